// File: rtl/pow2_unit.sv
// ============================================================================
// pow2_unit -- signed fixed-point antilog (2^E) for the GELU datapath
//
// Computes y = (result_sign ? -1 : +1) * 2^E with the Mitchell approximation
// 2^E ~= (1 + v) * 2^u. Here u is the integer part of E (floor) and v is the
// unsigned fractional part. Both E and y are Q5.26 signed fixed point by
// default.
//
// Pipeline: three stages behind a single valid/ready handshake.
//   S1 : split E into u / v and register them with the sign
//   S2 : shift the mantissa {1, v} by u, or saturate / underflow
//   S3 : apply the sign (two's complement) and present y
//
// All stages advance together whenever in_ready is high. While the output
// is stalled (valid_out & !out_ready), every stage holds its data and its
// valid bit.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   valid_in     in   1   exponent / result_sign are valid this cycle
//   in_ready     out  1   an input is accepted this cycle if valid_in is high
//   exponent     in   W   log2-domain value E (signed, Q fractional bits)
//   result_sign  in   1   1 = negate the result
//   valid_out    out  1   y / sat are valid
//   out_ready    in   1   downstream takes y this cycle
//   y            out  W   signed antilog result (Q fractional bits)
//   sat          out  1   result was clamped to the largest magnitude
// ============================================================================
module pow2_unit #(
    parameter int Q = 26,
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_in,
    output logic                in_ready,
    input  logic signed [W-1:0] exponent,
    input  logic                result_sign,
    output logic                valid_out,
    input  logic                out_ready,
    output logic signed [W-1:0] y,
    output logic                sat
);

    // Width of the integer part u. It spans the top W-Q bits of E.
    localparam int UW      = W - Q;
    // Largest left shift whose result still fits below the sign bit.
    localparam int MAX_LSH = W - Q - 2;
    // Shift amount at and above which the result saturates.
    localparam int SAT_U   = W - Q - 1;

    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_reg, s2_valid_reg, s3_valid_reg;
    logic advance;

    // The pipeline moves only when the output slot is free or being
    // emptied this cycle. There is no skid buffer, so the stall reaches
    // the input combinationally.
    assign in_ready  = out_ready | ~s3_valid_reg;
    assign advance   = in_ready;
    assign valid_out = s3_valid_reg;

    // ------------------------------------------------------------------
    // Stage 1 : split exponent into integer and fraction
    // ------------------------------------------------------------------
    logic signed [UW-1:0] s1_u_reg,    s1_u_next;
    logic        [Q-1:0]  s1_v_reg,    s1_v_next;
    logic                 s1_sign_reg, s1_sign_next;
    logic                 s1_valid_next;

    always_comb begin
        // An arithmetic shift right by Q keeps exactly the top W-Q bits as
        // a signed value. That is floor(E), even for negative E.
        s1_u_next     = $signed(exponent[W-1:Q]);
        s1_v_next     = exponent[Q-1:0];
        s1_sign_next  = result_sign;
        // A non-accepted cycle injects a bubble.
        s1_valid_next = valid_in & in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_u_reg     <= '0;
            s1_v_reg     <= '0;
            s1_sign_reg  <= 1'b0;
        end else if (advance) begin
            s1_valid_reg <= s1_valid_next;
            s1_u_reg     <= s1_u_next;
            s1_v_reg     <= s1_v_next;
            s1_sign_reg  <= s1_sign_next;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 : magnitude = {1, v} shifted by u, with saturation/underflow
    // ------------------------------------------------------------------
    logic [W-1:0]  mant_ext;
    logic [W-1:0]  lsh_cand [0:MAX_LSH];
    logic [UW-1:0] rsh_amt;
    int            u_int;

    logic [W-1:0]  s2_mag_reg,  s2_mag_next;
    logic          s2_sat_reg,  s2_sat_next;
    logic          s2_sign_reg;
    logic          s2_valid_reg_unused_guard;

    // Mantissa 1.v, zero-extended to the full data width. Its value in Q
    // format is 1 + v.
    assign mant_ext = {{(W-Q-1){1'b0}}, 1'b1, s1_v_reg};

    // The left shift amount is small and bounded, so the candidates are
    // precomputed and then selected. The shifter stays a narrow mux rather
    // than a full barrel shifter.
    generate
        for (genvar gi = 0; gi <= MAX_LSH; gi++) begin : g_lsh
            assign lsh_cand[gi] = mant_ext << gi;
        end
    endgenerate

    // Magnitude of a negative u, as an unsigned right-shift distance. The
    // most negative u (-2^(UW-1)) wraps to 2^(UW-1) in unsigned form. That
    // value is still a correct distance, and that case underflows anyway.
    assign rsh_amt = -s1_u_reg;

    always_comb begin
        u_int       = int'(s1_u_reg);
        s2_mag_next = '0;
        s2_sat_next = 1'b0;
        if (u_int >= SAT_U) begin
            s2_mag_next = MAX_POS;
            s2_sat_next = 1'b1;
        end else if (u_int >= 0) begin
            for (int i = 0; i <= MAX_LSH; i++) begin
                if (u_int == i) begin
                    s2_mag_next = lsh_cand[i];
                end
            end
        end else if (u_int >= -Q) begin
            // Bits shifted out below the LSB are truncated.
            s2_mag_next = mant_ext >> rsh_amt;
        end else begin
            // Even the leading 1 falls below the LSB, so the result is 0.
            s2_mag_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_mag_reg   <= '0;
            s2_sat_reg   <= 1'b0;
            s2_sign_reg  <= 1'b0;
        end else if (advance) begin
            s2_valid_reg <= s1_valid_reg;
            s2_mag_reg   <= s2_mag_next;
            s2_sat_reg   <= s2_sat_next;
            s2_sign_reg  <= s1_sign_reg;
        end
    end

    // Marks the S2 valid bit as part of the datapath bookkeeping. It has no
    // functional effect.
    assign s2_valid_reg_unused_guard = s2_valid_reg;

    // ------------------------------------------------------------------
    // Stage 3 : apply sign and present the result
    // ------------------------------------------------------------------
    logic signed [W-1:0] y_reg,      y_next;
    logic                s3_sat_reg;

    always_comb begin
        // Negating a saturated magnitude gives -(2^(W-1)-1), not the most
        // negative code. Negating zero yields zero.
        if (s2_sign_reg) begin
            y_next = -$signed(s2_mag_reg);
        end else begin
            y_next = $signed(s2_mag_reg);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_reg <= 1'b0;
            y_reg        <= '0;
            s3_sat_reg   <= 1'b0;
        end else if (advance) begin
            s3_valid_reg <= s2_valid_reg_unused_guard;
            y_reg        <= y_next;
            s3_sat_reg   <= s2_sat_reg;
        end
    end

    assign y   = y_reg;
    assign sat = s3_sat_reg;

endmodule

// File: tb/tb_pow2_unit.sv
// ============================================================================
// tb_pow2_unit -- scoreboard bench for pow2_unit
//
// The stimulus pushes hand-computed expectations when it presents an input.
// A monitor pops one expectation for each output transfer and compares it.
// ============================================================================
module tb_pow2_unit;

    logic               clk;
    logic               rst_n;
    logic               valid_in;
    logic               in_ready;
    logic signed [31:0] exponent;
    logic               result_sign;
    logic               valid_out;
    logic               out_ready;
    logic signed [31:0] y;
    logic               sat;

    pow2_unit #(.Q(26), .W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .in_ready    (in_ready),
        .exponent    (exponent),
        .result_sign (result_sign),
        .valid_out   (valid_out),
        .out_ready   (out_ready),
        .y           (y),
        .sat         (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        logic        sat;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   cyc_cnt  = 0;
    int   push_cnt = 0;
    int   xfer_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: a transfer happens at the next rising edge when valid_out
    // and out_ready are both high mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && valid_out && out_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_output: got y=%h sat=%b, required no output", y, sat);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("xfer %0d: y=%h sat=%b (want %h/%b) cyc=%0d",
                             xfer_cnt, y, sat, e.y, e.sat, cyc_cnt);
                    checks++;
                    if (y !== e.y) begin
                        errors++;
                        $display("FAIL y: got %h, required %h", y, e.y);
                    end
                    checks++;
                    if (sat !== e.sat) begin
                        errors++;
                        $display("FAIL sat: got %b, required %b (y=%h)", sat, e.sat, e.y);
                    end
                    if (e.chk_lat) begin
                        checks++;
                        if (cyc_cnt != e.cyc) begin
                            errors++;
                            $display("FAIL latency: result at cycle %0d, required cycle %0d", cyc_cnt, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Present one input and push its expectation once in_ready is seen
    // high. The input is then taken at the following rising edge.
    task automatic send(input logic [31:0] e, input logic s,
                        input logic [31:0] ey, input logic es, input bit lat);
        int   waited;
        exp_t x;
        @(negedge clk);
        valid_in    = 1'b1;
        exponent    = e;
        result_sign = s;
        #1;
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1 (E=%h)", in_ready, e);
        end else begin
            x.y       = ey;
            x.sat     = es;
            x.cyc     = cyc_cnt + 3;
            x.chk_lat = lat;
            exp_q.push_back(x);
            push_cnt++;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid_out) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    // Directed vectors: exponent, sign, expected y, expected sat
    typedef struct {
        logic [31:0] e;
        logic        s;
        logic [31:0] y;
        logic        sat;
    } vec_t;

    vec_t vecs[$] = '{
        '{32'h0000_0000, 1'b0, 32'h0400_0000, 1'b0},   // 2^0 = 1.0
        '{32'h0400_0000, 1'b0, 32'h0800_0000, 1'b0},   // 2^1 = 2.0
        '{32'h0200_0000, 1'b0, 32'h0600_0000, 1'b0},   // 2^0.5 ~ 1.5
        '{32'hFC00_0000, 1'b0, 32'h0200_0000, 1'b0},   // 2^-1 = 0.5
        '{32'h0400_0000, 1'b1, 32'hF800_0000, 1'b0},   // -2.0
        '{32'h1400_0000, 1'b0, 32'h7FFF_FFFF, 1'b1},   // u=5 saturates
        '{32'h1400_0000, 1'b1, 32'h8000_0001, 1'b1},   // negative saturation
        '{32'h9000_0000, 1'b0, 32'h0000_0000, 1'b0},   // u=-28 underflow
        '{32'h1000_0000, 1'b0, 32'h4000_0000, 1'b0},   // u=4 largest unsaturated
        '{32'h13FF_FFFF, 1'b0, 32'h7FFF_FFF0, 1'b0},   // u=4, v max
        '{32'h9800_0000, 1'b0, 32'h0000_0001, 1'b0},   // u=-26 keeps leading 1
        '{32'h9400_0000, 1'b0, 32'h0000_0000, 1'b0},   // u=-27 underflow edge
        '{32'h9BFF_FFFF, 1'b0, 32'h0000_0001, 1'b0},   // u=-26, fraction truncated
        '{32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0},   // u=-32, negated zero
        '{32'h7C00_0000, 1'b1, 32'h8000_0001, 1'b1},   // u=31 saturates
        '{32'hFE00_0000, 1'b1, 32'hFD00_0000, 1'b0}    // -(1.5/2)
    };

    vec_t bp_vecs[$] = '{
        '{32'h0000_0000, 1'b0, 32'h0400_0000, 1'b0},
        '{32'h0400_0000, 1'b0, 32'h0800_0000, 1'b0},
        '{32'h0800_0000, 1'b0, 32'h1000_0000, 1'b0},
        '{32'h0C00_0000, 1'b0, 32'h2000_0000, 1'b0},
        '{32'hF800_0000, 1'b0, 32'h0100_0000, 1'b0}
    };

    initial begin
        logic [31:0] held_y;
        int          n;
        bit          seen;

        rst_n       = 1'b0;
        valid_in    = 1'b0;
        exponent    = '0;
        result_sign = 1'b0;
        out_ready   = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_bit ("reset_valid_out", valid_out, 1'b0);
        check_bit ("reset_in_ready",  in_ready,  1'b1);
        check_word("reset_y",         y,         32'h0);
        check_bit ("reset_sat",       sat,       1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single isolated transactions (latency 3 each)
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].e, vecs[i].s, vecs[i].y, vecs[i].sat, 1'b1);
            idle();
            repeat (4) @(negedge clk);
        end

        // Remaining vectors back to back (throughput 1/cycle)
        for (int i = 4; i < vecs.size(); i++) begin
            send(vecs[i].e, vecs[i].s, vecs[i].y, vecs[i].sat, 1'b1);
        end
        idle();
        drain();

        // Backpressure: 5 back-to-back inputs with a 4-cycle stall
        fork
            begin
                for (int i = 0; i < bp_vecs.size(); i++) begin
                    send(bp_vecs[i].e, bp_vecs[i].s, bp_vecs[i].y, bp_vecs[i].sat, 1'b0);
                end
                idle();
            end
            begin
                n    = 0;
                seen = 1'b0;
                while (!seen && n < 50) begin
                    @(negedge clk);
                    seen = valid_out;
                    n++;
                end
                check_bit("bp_first_valid", seen, 1'b1);
                out_ready = 1'b0;
                held_y    = y;
                for (int k = 0; k < 4; k++) begin
                    #1;
                    check_bit ("bp_in_ready_low", in_ready,  1'b0);
                    check_bit ("bp_valid_held",   valid_out, 1'b1);
                    check_word("bp_y_held",       y,         held_y);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three results in flight
        for (int i = 0; i < 3; i++) begin
            send(bp_vecs[i].e, bp_vecs[i].s, bp_vecs[i].y, bp_vecs[i].sat, 1'b1);
        end
        @(negedge clk);
        valid_in = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_bit ("midrst_valid_out", valid_out, 1'b0);
        check_bit ("midrst_in_ready",  in_ready,  1'b1);
        check_word("midrst_y",         y,         32'h0);
        push_cnt = push_cnt - exp_q.size();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (valid_out) seen = 1'b1;
        end
        check_bit("post_reset_no_stale", seen, 1'b0);

        // Nothing lost or duplicated overall
        checks++;
        if (xfer_cnt != push_cnt) begin
            errors++;
            $display("FAIL transfer_count: got %0d, required %0d", xfer_cnt, push_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
